// File: rtl/l2_flush_seq_pkg.sv
// ============================================================================
// Module : l2_flush_seq_pkg
// Brief  : Shared L2 geometry constants, line-state encoding and flush FSM type
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l2_flush_seq_pkg;

   localparam int L2_SET_BITS       = 2;
   localparam int L2_WAY_BITS       = 1;
   localparam int L2_SETS           = 1 << L2_SET_BITS;
   localparam int L2_WAYS           = 1 << L2_WAY_BITS;
   localparam int REQS_BITS_P1      = 3;
   localparam int STABLE_STATE_BITS = 2;

   localparam logic [STABLE_STATE_BITS-1:0] INVALID = '0;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_READ      = 3'd2,
      ST_CHECK     = 3'd3,
      ST_WAIT_REQS = 3'd4,
      ST_EVICT     = 3'd5,
      ST_DONE      = 3'd6
   } flush_state_e;

endpackage

`default_nettype wire

// File: rtl/l2_flush_seq_if.sv
// ============================================================================
// Module : l2_flush_seq_if
// Brief  : Flush sequencer bundle: control, counter feedback, array read, evict
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface l2_flush_seq_if;
   import l2_flush_seq_pkg::*;

   logic                         flush_start;
   logic                         hold;
   logic [L2_SET_BITS:0]         flush_set;
   logic [L2_WAY_BITS:0]         flush_way;
   logic [REQS_BITS_P1-1:0]      reqs_cnt;
   logic                         rd_en;
   logic [L2_SET_BITS-1:0]       rd_set;
   logic [L2_WAY_BITS-1:0]       rd_way;
   logic [STABLE_STATE_BITS-1:0] rd_state;
   logic                         evict_valid;
   logic                         evict_ready;
   logic [L2_SET_BITS-1:0]       evict_set;
   logic [L2_WAY_BITS-1:0]       evict_way;
   logic [STABLE_STATE_BITS-1:0] evict_state;
   logic                         set_ongoing_flush;
   logic                         clr_ongoing_flush;
   logic                         incr_flush_set;
   logic                         clr_flush_set;
   logic                         incr_flush_way;
   logic                         clr_flush_way;
   logic                         fill_reqs_flush;
   logic                         flush_done;
   logic                         busy;

   // slave is the sequencer, master is the surrounding cache logic
   modport slave (
      input  flush_start, hold, flush_set, flush_way, reqs_cnt, rd_state, evict_ready,
      output rd_en, rd_set, rd_way, evict_valid, evict_set, evict_way, evict_state,
      output set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
      output incr_flush_way, clr_flush_way, fill_reqs_flush, flush_done, busy
   );

   modport master (
      output flush_start, hold, flush_set, flush_way, reqs_cnt, rd_state, evict_ready,
      input  rd_en, rd_set, rd_way, evict_valid, evict_set, evict_way, evict_state,
      input  set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
      input  incr_flush_way, clr_flush_way, fill_reqs_flush, flush_done, busy
   );

endinterface

`default_nettype wire

// File: rtl/l2_flush_seq.sv
// ============================================================================
// Module : l2_flush_seq
// Brief  : Walks every L2 set/way, evicting valid lines, driving external counters
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_flush_seq
   import l2_flush_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   l2_flush_seq_if.slave bus
);

   flush_state_e                 r_state;
   logic                         r_busy;
   logic                         r_start;
   logic                         r_done;
   logic                         r_evict_valid;
   logic [L2_SET_BITS-1:0]       r_set;
   logic [L2_WAY_BITS-1:0]       r_way;
   logic [STABLE_STATE_BITS-1:0] r_line_state;

   logic w_last_way;
   logic w_last_set;
   logic w_last_line;
   logic w_line_invalid;
   logic w_handshake;
   logic w_advance;
   logic w_rd_go;

   assign w_last_way     = (bus.flush_way == (L2_WAY_BITS+1)'(L2_WAYS-1));
   assign w_last_set     = (bus.flush_set == (L2_SET_BITS+1)'(L2_SETS-1));
   assign w_last_line    = w_last_way && w_last_set;
   assign w_line_invalid = (bus.rd_state == INVALID);
   assign w_handshake    = (r_state == ST_EVICT) && bus.evict_ready;
   assign w_advance      = ((r_state == ST_CHECK) && w_line_invalid) || w_handshake;
   assign w_rd_go        = (r_state == ST_READ) && !bus.hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_busy        <= 1'b0;
         r_start       <= 1'b0;
         r_done        <= 1'b0;
         r_evict_valid <= 1'b0;
         r_set         <= '0;
         r_way         <= '0;
         r_line_state  <= '0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.flush_start) begin
                  r_state <= ST_START;
                  r_busy  <= 1'b1;
                  r_start <= 1'b1;
               end
            end
            ST_START: r_state <= ST_READ;
            ST_READ: begin
               if (w_rd_go) begin
                  r_state <= ST_CHECK;
                  r_set   <= bus.flush_set[L2_SET_BITS-1:0];
                  r_way   <= bus.flush_way[L2_WAY_BITS-1:0];
               end
            end
            ST_CHECK: begin
               if (w_line_invalid) begin
                  r_state <= w_last_line ? ST_DONE : ST_READ;
                  r_done  <= w_last_line;
               end else begin
                  r_line_state <= bus.rd_state;
                  if (bus.reqs_cnt == '0) begin
                     r_state <= ST_WAIT_REQS;
                  end else begin
                     r_state       <= ST_EVICT;
                     r_evict_valid <= 1'b1;
                  end
               end
            end
            ST_WAIT_REQS: begin
               if (bus.reqs_cnt != '0) begin
                  r_state       <= ST_EVICT;
                  r_evict_valid <= 1'b1;
               end
            end
            ST_EVICT: begin
               // payload stays frozen in r_* until the consumer accepts it
               if (bus.evict_ready) begin
                  r_evict_valid <= 1'b0;
                  r_state       <= w_last_line ? ST_DONE : ST_READ;
                  r_done        <= w_last_line;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_en             = w_rd_go;
   assign bus.rd_set            = w_rd_go ? bus.flush_set[L2_SET_BITS-1:0] : '0;
   assign bus.rd_way            = w_rd_go ? bus.flush_way[L2_WAY_BITS-1:0] : '0;
   assign bus.evict_valid       = r_evict_valid;
   assign bus.evict_set         = r_set;
   assign bus.evict_way         = r_way;
   assign bus.evict_state       = r_line_state;
   assign bus.set_ongoing_flush = r_start;
   assign bus.clr_flush_set     = r_start;
   assign bus.clr_flush_way     = r_start || (w_advance && w_last_way);
   assign bus.incr_flush_way    = w_advance && !w_last_way;
   assign bus.incr_flush_set    = w_advance && w_last_way;
   assign bus.fill_reqs_flush   = w_handshake;
   assign bus.clr_ongoing_flush = r_done;
   assign bus.flush_done        = r_done;
   assign bus.busy              = r_busy;

endmodule

`default_nettype wire
